// File: rtl/audio_sched_pkg.sv
// Shared types and constants for the stereo channel scheduler.
package audio_sched_pkg;

   localparam int AUDIO_SAMPLE_WIDTH = 24;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEND_L = 3'd1,
      ST_WAIT_L = 3'd2,
      ST_SEND_R = 3'd3,
      ST_WAIT_R = 3'd4,
      ST_OUTPUT = 3'd5
   } sched_state_t;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } channel_t;

endpackage

// File: rtl/sched_watchdog.sv
// Per-channel watchdog: loadable cycle counter that flags expiry at TIMEOUT_CYCLES-1.
module sched_watchdog #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int COUNT_WIDTH    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_clear,
   input  logic                   i_load,
   input  logic [COUNT_WIDTH-1:0] i_load_value,
   input  logic                   i_enable,
   output logic                   o_expire
);

   localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [COUNT_WIDTH-1:0] count_q, count_d;

   // Parks at LAST so a stalled owner never sees the count wrap.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_load) begin
         count_d = i_load_value;
      end else if (i_enable && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_expire = (count_q == LAST);

endmodule

// File: rtl/audio_channel_scheduler.sv
// Time-multiplexes one mono core between left and right channels of a stereo stream,
// with a per-channel watchdog and saturating overrun/timeout accounting.
module audio_channel_scheduler
   import audio_sched_pkg::*;
#(
   parameter int DATA_WIDTH     = AUDIO_SAMPLE_WIDTH,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_data_valid,
   input  logic [DATA_WIDTH-1:0] i_data_left,
   input  logic [DATA_WIDTH-1:0] i_data_right,
   input  logic                  i_bypass,
   output logic                  o_core_valid,
   output logic [DATA_WIDTH-1:0] o_core_data,
   output logic                  o_core_channel,
   input  logic                  i_core_ready,
   input  logic                  i_core_result_valid,
   input  logic [DATA_WIDTH-1:0] i_core_result,
   output logic                  o_data_valid,
   output logic [DATA_WIDTH-1:0] o_data_left,
   output logic [DATA_WIDTH-1:0] o_data_right,
   output logic                  o_busy,
   output logic [CNT_WIDTH-1:0]  o_overrun_count,
   output logic [CNT_WIDTH-1:0]  o_timeout_count
);

   localparam int WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   sched_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0] lat_left_q, lat_left_d, lat_right_q, lat_right_d;
   logic [DATA_WIDTH-1:0] res_left_q, res_left_d, res_right_q, res_right_d;
   logic [DATA_WIDTH-1:0] out_left_q, out_left_d, out_right_q, out_right_d;
   logic [CNT_WIDTH-1:0]  overrun_q, overrun_d, timeout_q, timeout_d;
   logic                  in_channel, accept, handshake, timed_out, timeout_event;
   logic                  wd_expire, wd_clear, wd_load;
   channel_t              core_channel;

   assign in_channel = (state_q == ST_SEND_L) || (state_q == ST_WAIT_L) ||
                       (state_q == ST_SEND_R) || (state_q == ST_WAIT_R);
   assign accept     = i_data_valid && ((state_q == ST_IDLE) || (state_q == ST_OUTPUT));
   assign handshake  = o_core_valid && i_core_ready;
   assign timed_out  = in_channel && wd_expire;

   always_comb begin
      state_d       = state_q;
      lat_left_d    = lat_left_q;
      lat_right_d   = lat_right_q;
      res_left_d    = res_left_q;
      res_right_d   = res_right_q;
      out_left_d    = out_left_q;
      out_right_d   = out_right_q;
      overrun_d     = overrun_q;
      timeout_d     = timeout_q;
      timeout_event = 1'b0;

      // In WAIT_x a result in the expiry cycle wins over the watchdog.
      case (state_q)
         ST_IDLE, ST_OUTPUT: begin
            state_d = ST_IDLE;
            if (accept) begin
               lat_left_d  = i_data_left;
               lat_right_d = i_data_right;
               if (i_bypass) begin
                  res_left_d  = i_data_left;
                  res_right_d = i_data_right;
                  state_d     = ST_OUTPUT;
               end else begin
                  state_d = ST_SEND_L;
               end
            end
         end
         ST_SEND_L: begin
            if (timed_out) begin
               res_left_d    = lat_left_q;
               timeout_event = 1'b1;
               state_d       = ST_SEND_R;
            end else if (handshake) begin
               state_d = ST_WAIT_L;
            end
         end
         ST_WAIT_L: begin
            if (i_core_result_valid) begin
               res_left_d = i_core_result;
               state_d    = ST_SEND_R;
            end else if (timed_out) begin
               res_left_d    = lat_left_q;
               timeout_event = 1'b1;
               state_d       = ST_SEND_R;
            end
         end
         ST_SEND_R: begin
            if (timed_out) begin
               res_right_d   = lat_right_q;
               timeout_event = 1'b1;
               state_d       = ST_OUTPUT;
            end else if (handshake) begin
               state_d = ST_WAIT_R;
            end
         end
         ST_WAIT_R: begin
            if (i_core_result_valid) begin
               res_right_d = i_core_result;
               state_d     = ST_OUTPUT;
            end else if (timed_out) begin
               res_right_d   = lat_right_q;
               timeout_event = 1'b1;
               state_d       = ST_OUTPUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (i_data_valid && in_channel && (overrun_q != '1)) begin
         overrun_d = overrun_q + 1'b1;
      end
      if (timeout_event && (timeout_q != '1)) begin
         timeout_d = timeout_q + 1'b1;
      end
      if (state_d == ST_OUTPUT) begin
         out_left_d  = res_left_d;
         out_right_d = res_right_d;
      end

      wd_load  = ((state_d == ST_SEND_L) && (state_q != ST_SEND_L)) ||
                 ((state_d == ST_SEND_R) && (state_q != ST_SEND_R));
      wd_clear = !((state_d == ST_SEND_L) || (state_d == ST_WAIT_L) ||
                   (state_d == ST_SEND_R) || (state_d == ST_WAIT_R));
   end

   always_comb begin
      o_core_valid = 1'b0;
      o_core_data  = '0;
      core_channel = CH_LEFT;
      case (state_q)
         ST_SEND_L: begin
            o_core_valid = 1'b1;
            o_core_data  = lat_left_q;
         end
         ST_SEND_R: begin
            o_core_valid = 1'b1;
            o_core_data  = lat_right_q;
            core_channel = CH_RIGHT;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         lat_left_q  <= '0;
         lat_right_q <= '0;
         res_left_q  <= '0;
         res_right_q <= '0;
         out_left_q  <= '0;
         out_right_q <= '0;
         overrun_q   <= '0;
         timeout_q   <= '0;
      end else begin
         state_q     <= state_d;
         lat_left_q  <= lat_left_d;
         lat_right_q <= lat_right_d;
         res_left_q  <= res_left_d;
         res_right_q <= res_right_d;
         out_left_q  <= out_left_d;
         out_right_q <= out_right_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
      end
   end

   sched_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .COUNT_WIDTH    (WD_WIDTH)
   ) u_watchdog (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_clear      (wd_clear),
      .i_load       (wd_load),
      .i_load_value ('0),
      .i_enable     (in_channel),
      .o_expire     (wd_expire)
   );

   assign o_core_channel  = core_channel;
   assign o_data_valid    = (state_q == ST_OUTPUT);
   assign o_busy          = (state_q != ST_IDLE);
   assign o_data_left     = out_left_q;
   assign o_data_right    = out_right_q;
   assign o_overrun_count = overrun_q;
   assign o_timeout_count = timeout_q;

endmodule

// File: tb/tb_audio_channel_scheduler.sv
// Directed scoreboard bench for audio_channel_scheduler with a small echo-core model.
module tb_audio_channel_scheduler;

   localparam int DW = 24;
   localparam int TO = 16;
   localparam int CW = 8;

   typedef struct {
      logic [DW-1:0] left;
      logic [DW-1:0] right;
      int            acc;
      int            lat;
   } frame_t;

   typedef struct {
      logic          ch;
      logic [DW-1:0] data;
   } hs_t;

   logic          clk = 1'b0;
   logic          i_reset;
   logic          i_data_valid;
   logic [DW-1:0] i_data_left;
   logic [DW-1:0] i_data_right;
   logic          i_bypass;
   logic          o_core_valid;
   logic [DW-1:0] o_core_data;
   logic          o_core_channel;
   logic          i_core_ready;
   logic          i_core_result_valid;
   logic [DW-1:0] i_core_result;
   logic          o_data_valid;
   logic [DW-1:0] o_data_left;
   logic [DW-1:0] o_data_right;
   logic          o_busy;
   logic [CW-1:0] o_overrun_count;
   logic [CW-1:0] o_timeout_count;

   frame_t sb[$];
   hs_t    hs_q[$];
   int     n_cmp   = 0;
   int     n_bad   = 0;
   int     cyc     = 0;
   int     out_cnt = 0;
   int     exp_out = 0;
   int     hs_cnt  = 0;
   bit     resp_l  = 1'b1;
   bit     resp_r  = 1'b1;

   audio_channel_scheduler #(
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO),
      .CNT_WIDTH      (CW)
   ) dut (
      .i_clock             (clk),
      .i_reset             (i_reset),
      .i_data_valid        (i_data_valid),
      .i_data_left         (i_data_left),
      .i_data_right        (i_data_right),
      .i_bypass            (i_bypass),
      .o_core_valid        (o_core_valid),
      .o_core_data         (o_core_data),
      .o_core_channel      (o_core_channel),
      .i_core_ready        (i_core_ready),
      .i_core_result_valid (i_core_result_valid),
      .i_core_result       (i_core_result),
      .o_data_valid        (o_data_valid),
      .o_data_left         (o_data_left),
      .o_data_right        (o_data_right),
      .o_busy              (o_busy),
      .o_overrun_count     (o_overrun_count),
      .o_timeout_count     (o_timeout_count)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic byp);
      i_data_valid = 1'b1;
      i_data_left  = l;
      i_data_right = r;
      i_bypass     = byp;
   endtask

   // Called just before driving the accepting cycle; the accept edge is the next one.
   task automatic expect_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int lat);
      frame_t f;
      f.left  = l;
      f.right = r;
      f.acc   = cyc + 1;
      f.lat   = lat;
      sb.push_back(f);
      exp_out++;
   endtask

   task automatic expect_hs(input logic ch, input logic [DW-1:0] d);
      hs_t h;
      h.ch   = ch;
      h.data = d;
      hs_q.push_back(h);
   endtask

   task automatic wait_out();
      for (int i = 0; i < 100 && out_cnt < exp_out; i++) tick();
      chk("frame_done", 32'(out_cnt), 32'(exp_out));
   endtask

   // Output and handshake monitor.
   initial begin
      frame_t f;
      hs_t    h;
      forever begin
         @(negedge clk);
         if (o_data_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 32'(o_data_valid), 32'(0));
            end else begin
               f = sb.pop_front();
               chk("out_left", 32'(o_data_left), 32'(f.left));
               chk("out_right", 32'(o_data_right), 32'(f.right));
               chk("out_latency", 32'(cyc - f.acc + 1), 32'(f.lat));
            end
            out_cnt++;
         end
         if (o_core_valid === 1'b1 && i_core_ready === 1'b1) begin
            hs_cnt++;
            if (hs_q.size() == 0) begin
               chk("unexpected_hs", 32'(o_core_valid), 32'(0));
            end else begin
               h = hs_q.pop_front();
               chk("hs_channel", 32'(o_core_channel), 32'(h.ch));
               chk("hs_data", 32'(o_core_data), 32'(h.data));
            end
         end
      end
   end

   // Core model: echoes data XOR all-ones in the cycle after the handshake.
   initial begin
      bit            pend;
      logic [DW-1:0] pd;
      pend = 1'b0;
      pd   = '0;
      i_core_result_valid = 1'b0;
      i_core_result       = '0;
      forever begin
         @(negedge clk);
         i_core_result_valid = 1'b0;
         if (pend) begin
            i_core_result_valid = 1'b1;
            i_core_result       = pd ^ 24'hFFFFFF;
         end
         pend = 1'b0;
         if (o_core_valid === 1'b1 && i_core_ready === 1'b1 &&
             ((o_core_channel === 1'b1) ? resp_r : resp_l)) begin
            pend = 1'b1;
            pd   = o_core_data;
         end
      end
   end

   initial begin
      int h0;
      i_reset      = 1'b1;
      i_data_valid = 1'b0;
      i_data_left  = '0;
      i_data_right = '0;
      i_bypass     = 1'b0;
      i_core_ready = 1'b0;
      repeat (3) tick();
      chk("rst_busy", 32'(o_busy), 32'(0));
      chk("rst_core_valid", 32'(o_core_valid), 32'(0));
      chk("rst_data_valid", 32'(o_data_valid), 32'(0));
      chk("rst_data_left", 32'(o_data_left), 32'(0));
      chk("rst_overrun", 32'(o_overrun_count), 32'(0));
      chk("rst_timeout", 32'(o_timeout_count), 32'(0));
      i_reset = 1'b0;
      tick();

      // Nominal frame
      i_core_ready = 1'b1;
      h0 = hs_cnt;
      expect_hs(1'b0, 24'h123456);
      expect_hs(1'b1, 24'hFEDCBA);
      expect_frame(24'hEDCBA9, 24'h012345, 5);
      drive(24'h123456, 24'hFEDCBA, 1'b0);
      tick();
      i_data_valid = 1'b0;
      wait_out();
      tick();
      chk("hold_left", 32'(o_data_left), 32'h00EDCBA9);
      chk("hold_right", 32'(o_data_right), 32'h00012345);
      chk("nominal_hs_count", 32'(hs_cnt - h0), 32'(2));

      // Backpressure in SEND_L
      i_core_ready = 1'b0;
      h0 = hs_cnt;
      expect_hs(1'b0, 24'h0A0B0C);
      expect_hs(1'b1, 24'h102030);
      expect_frame(24'hF5F4F3, 24'hEFDFCF, 15);
      drive(24'h0A0B0C, 24'h102030, 1'b0);
      tick();
      i_data_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_core_valid", 32'(o_core_valid), 32'(1));
         chk("bp_core_data", 32'(o_core_data), 32'h000A0B0C);
         chk("bp_core_channel", 32'(o_core_channel), 32'(0));
         tick();
      end
      i_core_ready = 1'b1;
      wait_out();
      chk("bp_hs_count", 32'(hs_cnt - h0), 32'(2));

      // Right channel never answered
      resp_r = 1'b0;
      expect_hs(1'b0, 24'h111111);
      expect_hs(1'b1, 24'h222222);
      expect_frame(24'hEEEEEE, 24'h222222, 19);
      drive(24'h111111, 24'h222222, 1'b0);
      tick();
      i_data_valid = 1'b0;
      wait_out();
      chk("timeout_count", 32'(o_timeout_count), 32'(1));
      resp_r = 1'b1;
      tick();

      // Overrun during WAIT_L
      expect_hs(1'b0, 24'h300001);
      expect_hs(1'b1, 24'h300002);
      expect_frame(24'hCFFFFE, 24'hCFFFFD, 5);
      drive(24'h300001, 24'h300002, 1'b0);
      tick();
      i_data_valid = 1'b0;
      tick();
      drive(24'h400001, 24'h400002, 1'b0);
      tick();
      i_data_valid = 1'b0;
      wait_out();
      chk("overrun_count", 32'(o_overrun_count), 32'(1));
      tick();

      // Bypass back-to-back: IDLE accept then OUTPUT accept
      h0 = hs_cnt;
      expect_frame(24'h5A5A5A, 24'hA5A5A5, 1);
      drive(24'h5A5A5A, 24'hA5A5A5, 1'b1);
      tick();
      expect_frame(24'h000001, 24'h800000, 1);
      drive(24'h000001, 24'h800000, 1'b1);
      tick();
      i_data_valid = 1'b0;
      i_bypass     = 1'b0;
      wait_out();
      tick();
      chk("bypass_hs_count", 32'(hs_cnt - h0), 32'(0));
      chk("bypass_overrun", 32'(o_overrun_count), 32'(1));
      chk("bypass_idle", 32'(o_busy), 32'(0));

      // Reset asserted in WAIT_R
      resp_r = 1'b0;
      expect_hs(1'b0, 24'h777777);
      expect_hs(1'b1, 24'h666666);
      drive(24'h777777, 24'h666666, 1'b0);
      tick();
      i_data_valid = 1'b0;
      repeat (3) tick();
      chk("pre_reset_busy", 32'(o_busy), 32'(1));
      i_reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(o_busy), 32'(0));
      chk("mid_rst_core_valid", 32'(o_core_valid), 32'(0));
      chk("mid_rst_data_left", 32'(o_data_left), 32'(0));
      chk("mid_rst_data_right", 32'(o_data_right), 32'(0));
      chk("mid_rst_overrun", 32'(o_overrun_count), 32'(0));
      chk("mid_rst_timeout", 32'(o_timeout_count), 32'(0));
      repeat (2) tick();
      i_reset = 1'b0;
      resp_r  = 1'b1;
      tick();
      chk("post_rst_out_cnt", 32'(out_cnt), 32'(exp_out));

      // Normal frame after reset release
      expect_hs(1'b0, 24'h0F0F0F);
      expect_hs(1'b1, 24'hF0F0F0);
      expect_frame(24'hF0F0F0, 24'h0F0F0F, 5);
      drive(24'h0F0F0F, 24'hF0F0F0, 1'b0);
      tick();
      i_data_valid = 1'b0;
      wait_out();
      chk("post_rst_overrun", 32'(o_overrun_count), 32'(0));
      chk("post_rst_timeout", 32'(o_timeout_count), 32'(0));
      repeat (3) tick();

      chk("sb_drained", 32'(sb.size()), 32'(0));
      chk("hs_drained", 32'(hs_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/audio_channel_scheduler.md
Name: audio_channel_scheduler

Overview:
Time-multiplexes one mono processing core (filter/gain stage) between the left and right channels of the 24-bit stereo sample stream. Each stereo sample arrives as an `i_data_valid` pulse (one per ~22.7 us at 44.1 kHz). The block captures the pair and sends left, then right, to the core over a valid/ready handshake. It collects both results in order and emits one processed stereo pulse. It sits between the I2S/sample source and the output formatter, and it guards the frame with a per-channel watchdog and overrun accounting.

Parameters:
- `DATA_WIDTH`, 24: sample width in bits, signed two's complement.
- `TIMEOUT_CYCLES`, 256: maximum cycles spent per channel (send plus wait) before substitution.
- `CNT_WIDTH`, 8: width of the saturating overrun and timeout counters.

Ports:
- `i_clock`  in  1  system clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_data_valid`  in  1  one-cycle strobe, new stereo sample
- `i_data_left`  in  DATA_WIDTH  left sample, qualified by `i_data_valid`
- `i_data_right`  in  DATA_WIDTH  right sample, qualified by `i_data_valid`
- `i_bypass`  in  1  1 = skip the core and pass samples through
- `o_core_valid`  out  1  sample offered to the core
- `o_core_data`  out  DATA_WIDTH  sample to the core
- `o_core_channel`  out  1  0 = left, 1 = right
- `i_core_ready`  in  1  core accepts when `o_core_valid` & `i_core_ready`
- `i_core_result_valid`  in  1  one-cycle result strobe
- `i_core_result`  in  DATA_WIDTH  processed sample
- `o_data_valid`  out  1  one-cycle strobe, processed stereo pair
- `o_data_left`  out  DATA_WIDTH  processed left sample
- `o_data_right`  out  DATA_WIDTH  processed right sample
- `o_busy`  out  1  high in every state except IDLE
- `o_overrun_count`  out  CNT_WIDTH  dropped input samples, saturating
- `o_timeout_count`  out  CNT_WIDTH  channel timeouts, saturating

Behaviour:
- Reset values:
  - all outputs 0; state IDLE;
  - capture registers, counters and the watchdog cleared.
  - Reset asserted mid-frame aborts the frame with no output pulse; `o_core_valid` drops asynchronously.
- States: IDLE, SEND_L, WAIT_L, SEND_R, WAIT_R, OUTPUT.
- Accept:
  - `i_data_valid` is accepted in IDLE or OUTPUT.
  - On accept: latch left/right; next state is OUTPUT if `i_bypass`=1, else SEND_L.
  - `i_bypass` is sampled only at accept.
- Overrun: `i_data_valid` in SEND_*/WAIT_* drops the sample and increments `o_overrun_count` (saturates at all-ones). The frame in flight is unaffected.
- SEND_x:
  - `o_core_valid`=1; `o_core_data` = latched sample for channel x; `o_core_channel` = x.
  - Data is held stable until the handshake.
  - Handshake moves to WAIT_x.
- WAIT_x:
  - On `i_core_result_valid`, store `i_core_result` for channel x.
  - Then WAIT_L goes to SEND_R; WAIT_R goes to OUTPUT.
  - `i_core_result_valid` outside WAIT_* is ignored.
- Watchdog:
  - Counter cleared on entering SEND_x and held at 0 outside SEND_*/WAIT_*.
  - Increments each cycle in SEND_x/WAIT_x.
  - When it reaches `TIMEOUT_CYCLES`-1 without completion:
    - the stored result for x = the latched input for x (pass-through);
    - `o_timeout_count` increments (saturating);
    - the FSM advances as if the result had arrived;
    - `o_core_valid` deasserts.
  - A result arriving in the same cycle as the timeout wins; the counter is not incremented.
- OUTPUT (one cycle):
  - `o_data_valid`=1; `o_data_left`/`o_data_right` driven from the result registers, or from the inputs in bypass.
  - Next state is IDLE, or SEND_L/OUTPUT if a new sample is accepted in this cycle.
- Data hold: `o_data_left`/`o_data_right` hold their value between pulses.
- Latency:
  - With `i_core_ready`=1 and the result on the first WAIT cycle: 5 cycles from the accepting edge to `o_data_valid` high.
  - In bypass: 1 cycle.
- Arithmetic: no arithmetic on samples; widths preserved bit-exact.

Decomposition:
- Package `audio_sched_pkg`:
  - state enum `sched_state_t`;
  - channel enum `CH_LEFT`=0, `CH_RIGHT`=1;
  - constant `AUDIO_SAMPLE_WIDTH`=24.
- Sub-module `sched_watchdog`: loadable cycle counter with clear, enable, and an expire flag at `TIMEOUT_CYCLES`-1.

Test Plan:
- Nominal frame:
  - stimulus: left=24'h123456, right=24'hFEDCBA; core ready=1; echo the result in the first WAIT cycle as data XOR 24'hFFFFFF;
  - required: `o_data_valid` 5 cycles after accept, left=24'hEDCBA9, right=24'h012345; exactly 2 core handshakes, left first.
- Backpressure: hold `i_core_ready`=0 for 10 cycles in SEND_L → `o_core_data`/`o_core_channel` stable all 10 cycles; single handshake; output latency 15.
- Timeout:
  - stimulus: `TIMEOUT_CYCLES`=16; core never returns the right result;
  - required: `o_data_right` = input right; `o_timeout_count`=1; `o_data_valid` still pulses once.
- Overrun: second `i_data_valid` during WAIT_L → `o_overrun_count`=1; first frame output correct; second sample never reaches the core.
- Bypass / back-to-back: `i_bypass`=1 with samples on consecutive accept-eligible cycles (IDLE, then OUTPUT) → each pair output 1 cycle later; zero core handshakes; no overrun.
- Reset mid-frame: assert `i_reset` in WAIT_R → all outputs 0 immediately; no `o_data_valid`; the next frame after release processes normally with counters at 0.
